// File: rtl/cam_pwr_seq.sv
// rtl/cam_pwr_seq.sv - camera sensor power-up/restart sequencer; optional retry via CAM_SEQ_RETRY_EN
module cam_pwr_seq #(
  parameter int               CNT_W     = 16,
  parameter logic [CNT_W-1:0] T_PWDN    = 16'd1000,
  parameter logic [CNT_W-1:0] T_RST     = 16'd1000,
  parameter logic [CNT_W-1:0] T_SETTLE  = 16'd20000,
  parameter logic [CNT_W-1:0] T_TIMEOUT = 16'hffff,
  parameter logic [1:0]       MAX_RETRY = 2'd2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       soft_restart,
  input  logic       cfg_done,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       cfg_start,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_PWDN, S_RST, S_SETTLE, S_CFG, S_READY, S_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PWDN   = T_PWDN - 1'b1;
  localparam logic [CNT_W-1:0] LAST_RST    = T_RST - 1'b1;
  localparam logic [CNT_W-1:0] LAST_SETTLE = T_SETTLE - 1'b1;
  localparam logic [CNT_W-1:0] LAST_TO     = T_TIMEOUT - 1'b1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             done_ok, timeout;
  logic             pwdn_nx, rst_n_nx, start_nx, ready_nx, fail_nx;

  always_comb begin
    state_nx = state;
    // cfg_done on the cfg_start cycle (count 0) belongs to a previous request
    done_ok  = (state == S_CFG) && (cnt != '0) && cfg_done;
    timeout  = (state == S_CFG) && (cnt == LAST_TO);
    case (state)
      S_PWDN:   if (cnt == LAST_PWDN)   state_nx = S_RST;
      S_RST:    if (cnt == LAST_RST)    state_nx = S_SETTLE;
      S_SETTLE: if (cnt == LAST_SETTLE) state_nx = S_CFG;
      S_CFG: begin
        if (done_ok) begin
          state_nx = S_READY;
        end else if (timeout) begin
`ifdef CAM_SEQ_RETRY_EN
          state_nx = (retry_cnt < MAX_RETRY) ? S_PWDN : S_FAIL;
`else
          state_nx = S_FAIL;
`endif
        end
      end
      default:  state_nx = state;
    endcase
    if (soft_restart) state_nx = S_PWDN;

    cnt_clr  = soft_restart || (state_nx != state);
    pwdn_nx  = (state_nx == S_PWDN) || (state_nx == S_FAIL);
    rst_n_nx = (state_nx == S_SETTLE) || (state_nx == S_CFG) || (state_nx == S_READY);
    start_nx = (state_nx == S_CFG) && (state != S_CFG);
    ready_nx = (state_nx == S_READY);
    fail_nx  = (state_nx == S_FAIL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_PWDN;
      cnt       <= '0;
      cam_pwdn  <= 1'b1;
      cam_rst_n <= 1'b0;
      cfg_start <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_clr ? '0 : ((&cnt) ? cnt : cnt + 1'b1);
      cam_pwdn  <= pwdn_nx;
      cam_rst_n <= rst_n_nx;
      cfg_start <= start_nx;
      ready     <= ready_nx;
      fail      <= fail_nx;
    end
  end

`ifdef CAM_SEQ_RETRY_EN
  // a CFG->PWDN move without soft_restart can only be a retry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retry_cnt <= 2'd0;
    end else if (soft_restart) begin
      retry_cnt <= 2'd0;
    end else if (state == S_CFG && state_nx == S_PWDN) begin
      retry_cnt <= retry_cnt + 2'd1;
    end
  end
`else
  assign retry_cnt = MAX_RETRY & 2'b00;
`endif

endmodule

// File: tb/tb_cam_pwr_seq.sv
// tb/tb_cam_pwr_seq.sv - self-checking bench for cam_pwr_seq with a timeline model
module tb_cam_pwr_seq;

  localparam int TP = 4, TR = 3, TS = 5, TT = 8;
  localparam int CFG_AT = TP + TR + TS;
`ifdef CAM_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       soft_restart = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cam_pwdn, cam_rst_n, cfg_start, ready, fail;
  logic [1:0] retry_cnt;

  int checks = 0;
  int failures = 0;
  logic [6:0] obs [0:127];

  cam_pwr_seq #(
    .CNT_W(16), .T_PWDN(16'd4), .T_RST(16'd3), .T_SETTLE(16'd5),
    .T_TIMEOUT(16'd8), .MAX_RETRY(2'd2)
  ) dut (
    .clk(clk), .rstn(rstn), .soft_restart(soft_restart), .cfg_done(cfg_done),
    .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n), .cfg_start(cfg_start),
    .ready(ready), .fail(fail), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dut_vec();
    return {cam_pwdn, cam_rst_n, cfg_start, ready, fail, retry_cnt};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: the sequence is a timeline relative to its start cycle t0;
  // term is 0 while sequencing, 1 once ready, 2 once failed.
  task automatic run(input string nm, input int ncyc, input int done_c,
                     input int sr_c, input int rr_c);
    int t0, mret, term, rel;
    logic [6:0] exp;
    rstn = 1'b0; soft_restart = 1'b0; cfg_done = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    t0 = 0; mret = 0; term = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == rr_c) begin
        rstn = 1'b0;
        #1;
        chk({nm, " async_reset"}, dut_vec(), 7'b1000000);
        @(negedge clk);
        rstn = 1'b1;
        t0 = c + 1; mret = 0; term = 0;
        continue;
      end
      rel = c - t0;
      if (term == 1)      exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'(mret)};
      else if (term == 2) exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'(mret)};
      else exp = {rel < TP, rel >= TP + TR, rel == CFG_AT, 1'b0, 1'b0, 2'(mret)};
      obs[c] = dut_vec();
      checks++;
      if (obs[c] !== exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b expected %b", nm, c, obs[c], exp);
      end
      soft_restart = (c == sr_c);
      cfg_done     = (c == done_c);
      if (soft_restart) begin
        t0 = c + 1; mret = 0; term = 0;
      end else if (term == 0) begin
        if (cfg_done && rel > CFG_AT && rel <= CFG_AT + TT - 1) term = 1;
        else if (rel == CFG_AT + TT - 1) begin
          if (RETRY && mret < 2) begin mret++; t0 = c + 1; end
          else term = 2;
        end
      end
      @(negedge clk);
    end
    soft_restart = 1'b0; cfg_done = 1'b0;
  endtask

  initial begin
    run("nominal", 24, 15, -1, -1);
    chk("reset_state", obs[0], 7'b1000000);
    chk("pwdn_c3", obs[3][6], 1);
    chk("pwdn_c4", obs[4][6], 0);
    chk("rstn_c6", obs[6][5], 0);
    chk("rstn_c7", obs[7][5], 1);
    chk("start_c12", obs[12][4], 1);
    chk("start_c13", obs[13][4], 0);
    chk("ready_c15", obs[15][3], 0);
    chk("ready_c16", obs[16][3], 1);

    run("no_done", 70, -1, -1, -1);
    if (RETRY) begin
      chk("retry_c19", obs[19][1:0], 0);
      chk("retry_c20", obs[20][1:0], 1);
      chk("retry_c40", obs[40][1:0], 2);
      chk("start_c32", obs[32][4], 1);
      chk("start_c52", obs[52][4], 1);
      chk("fail_c59", obs[59][2], 0);
      chk("fail_c60", obs[60][2], 1);
    end else begin
      chk("fail_c19", obs[19][2], 0);
      chk("fail_c20", obs[20][2], 1);
      chk("park_pwdn_c20", obs[20][6], 1);
      chk("park_rstn_c20", obs[20][5], 0);
      chk("retry_zero", obs[30][1:0], 0);
    end

    run("done_at_timeout", 24, 19, -1, -1);
    chk("ready_c20", obs[20][3], 1);
    chk("fail_c20_low", obs[20][2], 0);

    run("restart_settle", 30, -1, 9, -1);
    chk("rs_pwdn_c10", obs[10][6], 1);
    chk("rs_rstn_c10", obs[10][5], 0);
    chk("rs_start_c12", obs[12][4], 0);
    chk("rs_start_c22", obs[22][4], 1);

    run("done_on_start", 24, 12, -1, -1);
    chk("ign_ready_c13", obs[13][3], 0);
    chk("ign_ready_c20", obs[20][3], 0);

    run("restart_ready", 28, 15, 18, -1);
    chk("rr_ready_c18", obs[18][3], 1);
    chk("rr_ready_c19", obs[19][3], 0);
    chk("rr_pwdn_c19", obs[19][6], 1);

    run("rstn_pulse", 45, -1, -1, 14);
    chk("rp_reset_c15", obs[15], 7'b1000000);
    chk("rp_rstn_c21", obs[21][5], 0);
    chk("rp_rstn_c22", obs[22][5], 1);
    chk("rp_start_c27", obs[27][4], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
